// File: rtl/sample_collector.sv
// Collects decimated ADC samples into the FFT input memory, then issues one
// start pulse per full frame and waits for the FFT to finish before refilling.
module sample_collector #(
  parameter int DATA_WIDTH   = 18,
  parameter int ADDR_WIDTH   = 4,
  parameter int SAMPLE_WIDTH = 12,
  parameter int DECIMATE     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    fft_done,
  output logic                    mic_we,
  output logic [ADDR_WIDTH-1:0]   mic_addr,
  output logic [DATA_WIDTH-1:0]   mic_data,
  output logic                    start,
  output logic [7:0]              frame_count,
  output logic                    overrun
);

  typedef enum logic [1:0] {FILL, TRIGGER, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int DEC_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIMATE - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = {ADDR_WIDTH{1'b1}};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DEC_W-1:0]        dec_q, dec_d;
  logic                    mic_we_q, mic_we_d;
  logic [ADDR_WIDTH-1:0]   mic_addr_q, mic_addr_d;
  logic [DATA_WIDTH-1:0]   mic_data_q, mic_data_d;
  logic                    start_q, start_d;
  logic [7:0]              frame_count_q, frame_count_d;
  logic                    overrun_q, overrun_d;

  // Offset-binary to two's complement: flip the MSB, then sign-extend.
  logic signed [SAMPLE_WIDTH-1:0] sample_s;
  assign sample_s = {~sample_in[SAMPLE_WIDTH-1], sample_in[SAMPLE_WIDTH-2:0]};

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    dec_d         = dec_q;
    mic_we_d      = 1'b0;
    mic_addr_d    = mic_addr_q;
    mic_data_d    = mic_data_q;
    start_d       = 1'b0;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    case (state_q)
      FILL: begin
        if (sample_valid) begin
          if (dec_q == DEC_LAST) begin
            dec_d = '0;
            if (fft_done) begin
              mic_we_d   = 1'b1;
              mic_addr_d = idx_q;
              mic_data_d = DATA_WIDTH'(sample_s);
              idx_d      = idx_q + ADDR_WIDTH'(1);
              if (idx_q == IDX_LAST) state_d = TRIGGER;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            dec_d = dec_q + DEC_W'(1);
          end
        end
      end
      // start is registered so it lands the cycle after the final write
      TRIGGER: begin
        start_d       = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
        state_d       = WAIT_BUSY;
      end
      WAIT_BUSY: if (!fft_done) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (fft_done) begin
          state_d = FILL;
          idx_d   = '0;
          dec_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
    if (state_q != FILL && sample_valid) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= FILL;
      idx_q         <= '0;
      dec_q         <= '0;
      mic_we_q      <= 1'b0;
      mic_addr_q    <= '0;
      mic_data_q    <= '0;
      start_q       <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dec_q         <= dec_d;
      mic_we_q      <= mic_we_d;
      mic_addr_q    <= mic_addr_d;
      mic_data_q    <= mic_data_d;
      start_q       <= start_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  assign mic_we      = mic_we_q;
  assign mic_addr    = mic_addr_q;
  assign mic_data    = mic_data_q;
  assign start       = start_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sample_collector.sv
// Bench for sample_collector: two instances (DECIMATE=1 and 3) share stimulus and
// are compared every cycle against a frame-level behavioural model.
module tb_sample_collector;
  localparam int DW = 18, AW = 4, SW = 12, N = 16;

  logic clk = 1'b0, rst = 1'b0, sv = 1'b0, fd = 1'b1;
  logic [SW-1:0] sin = '0;
  always #5 clk = ~clk;

  logic          o_we[2], o_start[2], o_ovr[2];
  logic [AW-1:0] o_addr[2];
  logic [DW-1:0] o_data[2];
  logic [7:0]    o_fc[2];

  sample_collector #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .DECIMATE(1)) u_d1 (
    .clk(clk), .rst(rst), .sample_valid(sv), .sample_in(sin), .fft_done(fd),
    .mic_we(o_we[0]), .mic_addr(o_addr[0]), .mic_data(o_data[0]), .start(o_start[0]),
    .frame_count(o_fc[0]), .overrun(o_ovr[0]));

  sample_collector #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .DECIMATE(3)) u_d3 (
    .clk(clk), .rst(rst), .sample_valid(sv), .sample_in(sin), .fft_done(fd),
    .mic_we(o_we[1]), .mic_addr(o_addr[1]), .mic_data(o_data[1]), .start(o_start[1]),
    .frame_count(o_fc[1]), .overrun(o_ovr[1]));

  // Reference model: expected outputs plus frame-progress bookkeeping
  bit            e_we[2], e_start[2], e_ovr[2];
  logic [AW-1:0] e_addr[2];
  logic [DW-1:0] e_data[2];
  int            e_fc[2];
  int            m_idx[2], m_cnt[2];
  bit            m_fill[2], m_start_due[2], m_busy_wait[2];
  int            checks = 0, errors = 0, starts1 = 0;

  task automatic model(input int k);
    int dec;
    dec = (k == 0) ? 1 : 3;
    if (!rst) begin
      e_we[k] = 0; e_start[k] = 0; e_ovr[k] = 0; e_addr[k] = '0; e_data[k] = '0; e_fc[k] = 0;
      m_idx[k] = 0; m_cnt[k] = 0; m_fill[k] = 1; m_start_due[k] = 0; m_busy_wait[k] = 0;
    end else begin
      e_we[k] = 0; e_start[k] = 0;
      if (m_fill[k]) begin
        if (sv) begin
          m_cnt[k]++;
          if (m_cnt[k] == dec) begin
            m_cnt[k] = 0;
            if (fd) begin
              e_we[k] = 1;
              e_addr[k] = AW'(m_idx[k]);
              e_data[k] = DW'(int'(sin) - 2048);
              m_idx[k]++;
              if (m_idx[k] == N) begin
                m_idx[k] = 0; m_fill[k] = 0; m_start_due[k] = 1;
              end
            end else e_ovr[k] = 1;
          end
        end
      end else begin
        if (sv) e_ovr[k] = 1;
        if (m_start_due[k]) begin
          m_start_due[k] = 0; e_start[k] = 1; e_fc[k] = (e_fc[k] + 1) % 256; m_busy_wait[k] = 1;
        end else if (m_busy_wait[k]) begin
          if (!fd) m_busy_wait[k] = 0;
        end else if (fd) begin
          m_fill[k] = 1; m_idx[k] = 0; m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model(0);
    model(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_we", k), 32'(o_we[k]), 32'(e_we[k]));
      chk($sformatf("d%0d_start", k), 32'(o_start[k]), 32'(e_start[k]));
      chk($sformatf("d%0d_ovr", k), 32'(o_ovr[k]), 32'(e_ovr[k]));
      chk($sformatf("d%0d_fc", k), 32'(o_fc[k]), 32'(e_fc[k]));
      chk($sformatf("d%0d_addr", k), 32'(o_addr[k]), 32'(e_addr[k]));
      chk($sformatf("d%0d_data", k), 32'(o_data[k]), 32'(e_data[k]));
    end
    if (o_start[0]) starts1++;
  endtask

  task automatic do_reset();
    rst = 1'b0; sv = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_fc", 32'(o_fc[0]), 32'd0);

    // First frame: codes 0..15, FFT idle throughout
    fd = 1'b1;
    for (int c = 0; c < N; c++) begin sv = 1'b1; sin = SW'(c); step(); end
    sv = 1'b0; step(); step();
    chk("frame1_fc", 32'(o_fc[0]), 32'd1);

    // Emulate an FFT run, then probe offset-binary conversion corners
    fd = 1'b0; step(); step();
    fd = 1'b1; step();
    sv = 1'b1; sin = 12'h800; step(); chk("conv_800", 32'(o_data[0]), 32'h00000);
    sin = 12'h000; step(); chk("conv_000", 32'(o_data[0]), 32'h3F800);
    sin = 12'hFFF; step(); chk("conv_fff", 32'(o_data[0]), 32'h007FF);
    for (int c = 3; c < N; c++) begin sin = SW'($urandom); step(); end
    sv = 1'b0; step(); step();

    // FFT busy with incoming strobes: drops and sticky overrun
    fd = 1'b0;
    for (int c = 0; c < 20; c++) begin sv = 1'b1; sin = SW'($urandom); step(); end
    chk("ovr_busy", 32'(o_ovr[0]), 32'd1);
    fd = 1'b1; sv = 1'b1; step();
    step();
    chk("refill_we", 32'(o_we[0]), 32'd1);
    chk("refill_addr", 32'(o_addr[0]), 32'd0);
    sv = 1'b0;

    // Randomized traffic with a wandering fft_done
    for (int c = 0; c < 800; c++) begin
      sv = 1'($urandom_range(0, 1));
      sin = SW'($urandom);
      if ($urandom_range(0, 11) == 0) fd = ~fd;
      step();
    end

    // Reset mid-frame discards the partial frame
    fd = 1'b1;
    do_reset();
    for (int c = 0; c < 7; c++) begin sv = 1'b1; sin = SW'($urandom); step(); end
    rst = 1'b0; sv = 1'b1; step();
    chk("midrst_we", 32'(o_we[0]), 32'd0);
    chk("midrst_addr", 32'(o_addr[0]), 32'd0);
    rst = 1'b1; starts1 = 0;
    for (int c = 0; c < N; c++) begin sv = 1'b1; sin = SW'($urandom); step(); end
    sv = 1'b0; step(); step(); step();
    chk("midrst_starts", 32'(starts1), 32'd1);

    // 256 back-to-back frames: frame_count wraps to zero
    do_reset();
    fd = 1'b1; starts1 = 0;
    for (int f = 0; f < 256; f++) begin
      for (int c = 0; c < N; c++) begin sv = 1'b1; sin = SW'($urandom); step(); end
      sv = 1'b0; step(); step();
      fd = 1'b0; step();
      fd = 1'b1; step();
    end
    chk("wrap_starts", 32'(starts1), 32'd256);
    chk("wrap_fc", 32'(o_fc[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_collector.md
SAMPLE_COLLECTOR -- requirements
Module: sample_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, FFT memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, log2 of frame length N (N = 2**ADDR_WIDTH).
REQ-003 SHALL have parameter SAMPLE_WIDTH, default 12, ADC sample width; SAMPLE_WIDTH <= DATA_WIDTH required.
REQ-004 SHALL have parameter DECIMATE, default 1, keep 1 of every DECIMATE valid samples; DECIMATE >= 1.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port sample_valid, input, 1, one-cycle strobe qualifying sample_in.
REQ-008 SHALL have port sample_in, input, SAMPLE_WIDTH, unsigned offset-binary ADC code.
REQ-009 SHALL have port fft_done, input, 1, FFT controller idle flag; memory writable only while high.
REQ-010 SHALL have port mic_we, output, 1, FFT memory write enable.
REQ-011 SHALL have port mic_addr, output, ADDR_WIDTH, natural-order sample index; bit reversal is done downstream.
REQ-012 SHALL have port mic_data, output, DATA_WIDTH, signed sample to FFT memory.
REQ-013 SHALL have port start, output, 1, one-cycle FFT start pulse.
REQ-014 SHALL have port frame_count, output, 8, frames handed to FFT, wraps 255->0.
REQ-015 SHALL have port overrun, output, 1, sticky flag: a kept sample was dropped.

Function
REQ-016 SHALL implement FSM states FILL, TRIGGER, WAIT_BUSY, WAIT_DONE.
REQ-017 Decimation counter SHALL count sample_valid strobes in FILL 0..DECIMATE-1; strobe with counter==DECIMATE-1 is "kept", counter then returns 0.
REQ-018 FILL: kept strobe with fft_done=1 at cycle t SHALL give mic_we=1 at t+1 with mic_addr = write index, index then increments.
REQ-019 mic_data SHALL be {~sample_in[MSB], sample_in[MSB-1:0]} sign-extended to DATA_WIDTH, registered alongside mic_we.
REQ-020 mic_we, mic_addr, mic_data SHALL be registered; mic_we high exactly one cycle per write; mic_addr/mic_data hold last values when mic_we=0.
REQ-021 Write at index N-1 SHALL move FSM to TRIGGER; index wraps to 0.
REQ-022 TRIGGER: start=1 for exactly one cycle (cycle after last mic_we), frame_count increments same cycle, next state WAIT_BUSY.
REQ-023 WAIT_BUSY: remain until fft_done=0, then WAIT_DONE.
REQ-024 WAIT_DONE: remain until fft_done=1, then FILL with index 0, decimation counter 0.
REQ-025 Kept strobe in FILL with fft_done=0 SHALL be dropped, overrun set, index unchanged.
REQ-026 sample_valid in TRIGGER, WAIT_BUSY, WAIT_DONE SHALL be dropped without affecting decimation counter; overrun set.
REQ-027 overrun SHALL clear only on reset.
REQ-028 sample_valid on the cycle FSM returns to FILL SHALL be dropped (state evaluated before transition).

Reset
REQ-029 rst=0 at clock edge SHALL force FILL, index 0, decimation counter 0, mic_we=0, mic_addr=0, mic_data=0, start=0, frame_count=0, overrun=0.
REQ-030 Reset mid-frame or mid-FFT SHALL discard partial frame; no start issued for it.
REQ-031 Reset SHALL take priority over all inputs same cycle.

Verification
REQ-032 ADDR_WIDTH=4, DECIMATE=1, fft_done=1, 16 strobes of codes 0..15 -> mic_we 16 times, mic_addr 0..15, mic_data = signed(code^0x800) sign-extended, start one cycle after 16th write, frame_count=1.
REQ-033 sample_in=0x800 -> mic_data=0; 0x000 -> 0x3F800 (18-bit); 0xFFF -> 0x007FF.
REQ-034 DECIMATE=3, 48 strobes -> 16 writes on strobes 3,6,...,48; start once.
REQ-035 After start, fft_done low 20 cycles with strobes -> no mic_we, overrun=1; fft_done high -> next kept strobe writes mic_addr=0.
REQ-036 rst=0 after 7 writes -> all outputs at reset values; next 16 strobes produce addr 0..15 and one start.
REQ-037 256 full frames -> frame_count wraps to 0, start count 256.
